// File: rtl/syn_lb_mstr.sv
// syn_lb_mstr: single-outstanding host-to-local-bus initiator; optional ack timeout via SYN_LB_MSTR_TIMEOUT_EN
module syn_lb_mstr #(
  parameter int P_DATA_W = 32,
  parameter int P_ADDR_W = 8,
  parameter int P_TIMEOUT = 255,
  parameter logic [P_DATA_W-1:0] P_TIMEOUT_DATA = 32'hdeadbeef
) (
  input  logic                clk_ir,
  input  logic                rst_sync_l,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [P_ADDR_W-1:0] req_addr,
  input  logic [P_DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [P_DATA_W-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                lb_wr_en,
  output logic                lb_rd_en,
  output logic [P_ADDR_W-1:0] lb_addr,
  output logic [P_DATA_W-1:0] lb_wr_data,
  input  logic                lb_wr_valid,
  input  logic                lb_rd_valid,
  input  logic [P_DATA_W-1:0] lb_rd_data,
  output logic [7:0]          timeout_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic wr_q;
  logic ack;
  assign ack = wr_q ? lb_wr_valid : lb_rd_valid;
  if (P_TIMEOUT < 2 || $bits(P_TIMEOUT_DATA) != P_DATA_W) begin : g_bad_cfg
    $error("syn_lb_mstr: P_TIMEOUT must be at least 2");
  end
`ifdef SYN_LB_MSTR_TIMEOUT_EN
  localparam int CW = $clog2(P_TIMEOUT);
  logic [CW-1:0] wait_cnt;
`else
  assign rsp_err = 1'b0;
  assign timeout_cnt = 8'd0;
`endif
  // Transaction FSM: accept a request, strobe once, wait for the matching ack, hold the response until taken
  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) begin
      state <= IDLE;
      wr_q <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      lb_wr_en <= 1'b0;
      lb_rd_en <= 1'b0;
      lb_addr <= '0;
      lb_wr_data <= '0;
`ifdef SYN_LB_MSTR_TIMEOUT_EN
      rsp_err <= 1'b0;
      timeout_cnt <= 8'd0;
      wait_cnt <= '0;
`endif
    end else begin
      lb_wr_en <= 1'b0;
      lb_rd_en <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          state <= ISSUE;
          req_ready <= 1'b0;
          wr_q <= req_wr;
          lb_addr <= req_addr;
          lb_wr_data <= req_wdata;
          lb_wr_en <= req_wr;
          lb_rd_en <= !req_wr;
        end
        ISSUE: begin
          state <= WAIT;
`ifdef SYN_LB_MSTR_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: if (ack) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= wr_q ? '0 : lb_rd_data;
`ifdef SYN_LB_MSTR_TIMEOUT_EN
          rsp_err <= 1'b0;
        end else if (wait_cnt == CW'(P_TIMEOUT - 1)) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= wr_q ? '0 : P_TIMEOUT_DATA;
          rsp_err <= 1'b1;
          timeout_cnt <= timeout_cnt + {7'd0, ~&timeout_cnt};
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
`endif
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_syn_lb_mstr.sv
// tb_syn_lb_mstr: table-driven and randomized transaction checks of syn_lb_mstr
module tb_syn_lb_mstr;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_l, req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
  logic lb_wr_en, lb_rd_en, lb_wr_valid, lb_rd_valid;
  logic [AW-1:0] req_addr, lb_addr;
  logic [DW-1:0] req_wdata, rsp_rdata, lb_wr_data, lb_rd_data;
  logic [7:0] timeout_cnt;
  int checks = 0;
  int failures = 0;

  syn_lb_mstr #(.P_TIMEOUT(TO)) dut (
    .clk_ir(clk), .rst_sync_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
    .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data),
    .timeout_cnt(timeout_cnt)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] rdata;
    int          rdy_dly;
    logic        noise;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];

  // reference: a write returns zero, a read returns whatever the slave handed back with its ack
  function automatic logic [31:0] ref_rsp(input logic wr, input logic [31:0] slave_data);
    return wr ? 32'h0 : slave_data;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_strobes"}, 32'({lb_wr_en, lb_rd_en}), 32'd0);
    chk({tag, "_lb_addr"}, 32'(lb_addr), 32'd0);
    chk({tag, "_lb_wr_data"}, lb_wr_data, 32'd0);
    chk({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    logic hit;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    step();
    req_valid = v.noise; req_wr = ~v.wr; req_addr = ~v.addr; req_wdata = ~v.wdata;
    lb_wr_valid = v.noise; lb_rd_valid = v.noise; lb_rd_data = 32'h55;
    chk("issue_wr_en", 32'(lb_wr_en), 32'(v.wr));
    chk("issue_rd_en", 32'(lb_rd_en), 32'(!v.wr));
    chk("issue_lb_addr", 32'(lb_addr), 32'(v.addr));
    chk("issue_lb_wr_data", lb_wr_data, v.wdata);
    chk("busy_req_ready", 32'(req_ready), 32'd0);
    step();
    for (int k = 1; k <= v.ack_dly; k++) begin
      hit = (k == v.ack_dly);
      lb_wr_valid = v.wr ? hit : v.noise;
      lb_rd_valid = v.wr ? v.noise : hit;
      lb_rd_data = hit ? v.rdata : 32'($urandom());
      step();
      if (!hit) begin
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("wait_strobes", 32'({lb_wr_en, lb_rd_en}), 32'd0);
        chk("wait_lb_addr", 32'(lb_addr), 32'(v.addr));
      end
    end
    lb_wr_valid = 1'b0; lb_rd_valid = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'd0);
    for (int j = 0; j < v.rdy_dly; j++) begin
      lb_wr_valid = v.noise; lb_rd_valid = v.noise; lb_rd_data = 32'($urandom());
      step();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    lb_wr_valid = 1'b0; lb_rd_valid = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0;
    step();
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic seen;
    vecs[0] = '{1'b1, 8'h10, 32'h1,        1,  32'h0,        0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 8'h14, 32'h0,        4,  32'h3,        5, 1'b0, 32'h3};
    vecs[2] = '{1'b0, 8'h20, 32'h0,        1,  32'hAA,       1, 1'b1, 32'hAA};
    vecs[3] = '{1'b1, 8'hFF, 32'hFFFFFFFF, TO, 32'h12345678, 2, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 8'h00, 32'h0,        2,  32'hFFFFFFFF, 0, 1'b0, 32'hFFFFFFFF};
    vecs[5] = '{1'b0, 8'h80, 32'h12345678, 3,  32'h0,        3, 1'b1, 32'h0};
    rst_l = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; lb_wr_valid = 1'b0; lb_rd_valid = 1'b0; lb_rd_data = '0;
    step();
    step();
    chk_idle_outs("reset");
    rst_l = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        lb_rd_valid = 1'b1; lb_wr_valid = 1'b1; lb_rd_data = 32'h55;
        step();
        lb_rd_valid = 1'b0; lb_wr_valid = 1'b0;
        chk("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("spurious_rsp_rdata", rsp_rdata, vecs[i-1].exp_rdata);
      end
      run_txn(vecs[i]);
    end
    // write acknowledged only with the wrong ack type
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h30; req_wdata = 32'h77;
    step();
    req_valid = 1'b0; lb_rd_valid = 1'b1; lb_rd_data = 32'h99;
    step();
    seen = 1'b0;
`ifdef SYN_LB_MSTR_TIMEOUT_EN
    for (int k = 0; k < TO - 1; k++) begin
      step();
      seen |= rsp_valid;
    end
    chk("wrongack_early_rsp", 32'(seen), 32'd0);
    step();
    chk("wrongack_to_valid", 32'(rsp_valid), 32'd1);
    chk("wrongack_to_err", 32'(rsp_err), 32'd1);
    chk("wrongack_to_rdata", rsp_rdata, 32'h0);
    chk("wrongack_to_cnt", 32'(timeout_cnt), 32'd1);
`else
    for (int k = 0; k < 40; k++) begin
      step();
      seen |= rsp_valid;
    end
    chk("wrongack_stuck_rsp", 32'(seen), 32'd0);
    chk("wrongack_err", 32'(rsp_err), 32'd0);
    chk("wrongack_to_cnt", 32'(timeout_cnt), 32'd0);
    lb_rd_valid = 1'b0; lb_wr_valid = 1'b1;
    step();
    lb_wr_valid = 1'b0;
    chk("wrongack_late_valid", 32'(rsp_valid), 32'd1);
    chk("wrongack_late_rdata", rsp_rdata, 32'h0);
`endif
    lb_rd_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wrongack_done", 32'(req_ready), 32'd1);
    // reset while waiting, then a late ack that must be dropped
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h44; req_wdata = 32'h4;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    chk_idle_outs("midrst");
    lb_rd_valid = 1'b1; lb_rd_data = 32'hBAD;
    step();
    lb_rd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      seen |= rsp_valid;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    chk_idle_outs("midrst_late");
    v = '{1'b0, 8'h44, 32'h0, 1, 32'hC0FFEE, 1, 1'b0, 32'hC0FFEE};
    run_txn(v);
`ifdef SYN_LB_MSTR_TIMEOUT_EN
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'(i);
      step();
      req_valid = 1'b0;
      step();
      for (int k = 0; k < TO - 1; k++) step();
      step();
      chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
      if (i == 0) begin
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'hdeadbeef);
        chk("to_cnt_first", 32'(timeout_cnt), 32'd1);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
    chk("to_cnt_sat", 32'(timeout_cnt), 32'd255);
`endif
    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.addr = 8'($urandom());
      v.wdata = 32'($urandom());
      v.ack_dly = int'($urandom_range(1, 8));
      v.rdata = 32'($urandom());
      v.rdy_dly = int'($urandom_range(0, 3));
      v.noise = 1'($urandom_range(0, 1));
      v.exp_rdata = ref_rsp(v.wr, v.rdata);
      run_txn(v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
